phase_scheduler: RTL and testbench

PHASE_SCHEDULER -- requirements
Module: phase_scheduler

---
 rtl/tl_pkg.sv | 45 ++++
 rtl/phase_scheduler_if.sv | 35 +++
 rtl/tick_prescaler.sv | 30 +++
 rtl/phase_scheduler.sv | 205 ++++++++++++++++++++
 tb/tb_phase_scheduler.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tl_pkg.sv
// Shared traffic-light definitions: phase encodings, direction codes and
// the small combinational helpers used by the phase scheduler.
package tl_pkg;

    typedef enum logic [1:0] {
        REST_RED = 2'd0,
        GREEN    = 2'd1,
        YELLOW   = 2'd2,
        ALL_RED  = 2'd3
    } phase_t;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    // First requesting direction after 'last', wrapping; 'last' itself is
    // checked last so a lone requester can be re-granted.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    function automatic logic [7:0] clamp_dur(input logic [7:0] dur);
        return (dur == 8'd0) ? 8'd1 : dur;
    endfunction

    function automatic logic [3:0] dir_onehot(input logic [1:0] dir);
        return 4'b0001 << dir;
    endfunction

endpackage

// File: rtl/phase_scheduler_if.sv
// Bundle of the scheduler's demand, configuration and lamp signals, with a
// controller-side (master) and scheduler-side (slave) view.
interface phase_scheduler_if;
    import tl_pkg::*;

    logic [3:0] req;
    logic       emerg_valid;
    logic [1:0] emerg_dir;
    logic [7:0] min_green;
    logic [7:0] max_green;
    logic [7:0] yellow_dur;
    logic [7:0] all_red_dur;
    logic [3:0] lamp_red;
    logic [3:0] lamp_yellow;
    logic [3:0] lamp_green;
    logic [1:0] active_dir;
    logic [7:0] countdown;
    logic [1:0] phase;
    logic       emerg_ack;

    modport master (
        output req, emerg_valid, emerg_dir,
        output min_green, max_green, yellow_dur, all_red_dur,
        input  lamp_red, lamp_yellow, lamp_green,
        input  active_dir, countdown, phase, emerg_ack
    );

    modport slave (
        input  req, emerg_valid, emerg_dir,
        input  min_green, max_green, yellow_dur, all_red_dur,
        output lamp_red, lamp_yellow, lamp_green,
        output active_dir, countdown, phase, emerg_ack
    );

endinterface

// File: rtl/tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles; restart
// realigns the count so the next tick is a full period away.
module tick_prescaler #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_r;

    // Free-running modulo-TICK_DIV counter, cleared on reset and phase entry.
    always_ff @(posedge clk) begin
        if (reset || restart) begin
            cnt_r <= '0;
        end else if (cnt_r == LAST) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_r + CW'(1);
        end
    end

    assign tick = (cnt_r == LAST);

endmodule

// File: rtl/phase_scheduler.sv
// Four-way intersection phase scheduler: round-robin green grants with
// min/max green timing, yellow and all-red clearance, and emergency preemption.
module phase_scheduler
    import tl_pkg::*;
#(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       emerg_valid,
    input  logic [1:0] emerg_dir,
    input  logic [7:0] min_green,
    input  logic [7:0] max_green,
    input  logic [7:0] yellow_dur,
    input  logic [7:0] all_red_dur,
    output logic [3:0] lamp_red,
    output logic [3:0] lamp_yellow,
    output logic [3:0] lamp_green,
    output logic [1:0] active_dir,
    output logic [7:0] countdown,
    output logic [1:0] phase,
    output logic       emerg_ack
);

    phase_t     state_r, state_next;
    logic [1:0] dir_next;
    logic [7:0] elapsed_r, elapsed_next;
    logic [7:0] rem_r, rem_next;
    logic [7:0] min_r, min_next;
    logic [7:0] max_r, max_next;
    logic       armed_r, armed_next;
    logic       ack_next;

    logic       tick_s, restart_s;
    logic [7:0] min_eff_s, max_eff_s, cur_rem_s, el_s;
    logic       grant_s, hold_s, preempt_s, other_s, other_next_s;
    logic [1:0] grant_dir_s;
    logic [3:0] red_next, yel_next, grn_next;
    logic [7:0] cd_next;

    tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .restart (restart_s),
        .tick    (tick_s)
    );

    assign restart_s = (state_next != state_r);
    assign phase     = state_r;

    // Clamped durations, grant choice and green-phase qualifiers.
    always_comb begin
        min_eff_s   = clamp_dur(min_green);
        max_eff_s   = (max_green < min_eff_s) ? min_eff_s : max_green;
        // armed_r is clear only in the first all-red after reset, which has
        // not latched its duration yet.
        cur_rem_s   = armed_r ? rem_r : clamp_dur(all_red_dur);
        grant_s     = emerg_valid | (|req);
        grant_dir_s = emerg_valid ? emerg_dir : rr_pick(req, active_dir);
        el_s        = (tick_s && (elapsed_r < max_r)) ? elapsed_r + 8'd1 : elapsed_r;
        other_s     = |(req & ~dir_onehot(active_dir));
        hold_s      = emerg_ack ? emerg_valid : (emerg_valid && (emerg_dir == active_dir));
        preempt_s   = !emerg_ack && emerg_valid && (emerg_dir != active_dir);
    end

    // Next-state and timer update.
    always_comb begin
        state_next   = state_r;
        dir_next     = active_dir;
        elapsed_next = elapsed_r;
        rem_next     = rem_r;
        min_next     = min_r;
        max_next     = max_r;
        armed_next   = armed_r;
        ack_next     = emerg_ack;
        case (state_r)
            REST_RED: begin
                if (grant_s) begin
                    state_next   = GREEN;
                    dir_next     = grant_dir_s;
                    ack_next     = emerg_valid;
                    elapsed_next = 8'd0;
                    min_next     = min_eff_s;
                    max_next     = max_eff_s;
                end else begin
                    state_next = REST_RED;
                end
            end
            GREEN: begin
                elapsed_next = el_s;
                ack_next     = hold_s;
                if (preempt_s || (!hold_s && (el_s >= min_r) && other_s)) begin
                    state_next = YELLOW;
                    rem_next   = clamp_dur(yellow_dur);
                    ack_next   = 1'b0;
                end else begin
                    state_next = GREEN;
                end
            end
            YELLOW: begin
                if (tick_s && (rem_r <= 8'd1)) begin
                    state_next = ALL_RED;
                    rem_next   = clamp_dur(all_red_dur);
                    armed_next = 1'b1;
                end else if (tick_s) begin
                    rem_next = rem_r - 8'd1;
                end else begin
                    rem_next = rem_r;
                end
            end
            ALL_RED: begin
                armed_next = 1'b1;
                if (tick_s && (cur_rem_s <= 8'd1)) begin
                    if (grant_s) begin
                        state_next   = GREEN;
                        dir_next     = grant_dir_s;
                        ack_next     = emerg_valid;
                        elapsed_next = 8'd0;
                        min_next     = min_eff_s;
                        max_next     = max_eff_s;
                    end else begin
                        state_next = REST_RED;
                        rem_next   = 8'd0;
                    end
                end else if (tick_s) begin
                    rem_next = cur_rem_s - 8'd1;
                end else begin
                    rem_next = cur_rem_s;
                end
            end
            default: begin
                state_next = ALL_RED;
            end
        endcase
    end

    // Lamp and countdown values for the phase being entered.
    always_comb begin
        red_next     = 4'b1111;
        yel_next     = 4'b0000;
        grn_next     = 4'b0000;
        cd_next      = 8'd0;
        other_next_s = |(req & ~dir_onehot(dir_next));
        case (state_next)
            GREEN: begin
                grn_next = dir_onehot(dir_next);
                red_next = ~dir_onehot(dir_next);
                if (elapsed_next < min_next) begin
                    cd_next = min_next - elapsed_next;
                end else if (other_next_s && (elapsed_next < max_next)) begin
                    cd_next = max_next - elapsed_next;
                end else begin
                    cd_next = 8'd0;
                end
            end
            YELLOW: begin
                yel_next = dir_onehot(dir_next);
                red_next = ~dir_onehot(dir_next);
                cd_next  = rem_next;
            end
            ALL_RED: begin
                cd_next = rem_next;
            end
            REST_RED: begin
                cd_next = 8'd0;
            end
            default: begin
                cd_next = 8'd0;
            end
        endcase
    end

    // State, timers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ALL_RED;
            active_dir  <= DIR_W;
            elapsed_r   <= 8'd0;
            rem_r       <= 8'd0;
            min_r       <= 8'd0;
            max_r       <= 8'd0;
            armed_r     <= 1'b0;
            emerg_ack   <= 1'b0;
            countdown   <= 8'd0;
            lamp_red    <= 4'b1111;
            lamp_yellow <= 4'b0000;
            lamp_green  <= 4'b0000;
        end else begin
            state_r     <= state_next;
            active_dir  <= dir_next;
            elapsed_r   <= elapsed_next;
            rem_r       <= rem_next;
            min_r       <= min_next;
            max_r       <= max_next;
            armed_r     <= armed_next;
            emerg_ack   <= ack_next;
            countdown   <= cd_next;
            lamp_red    <= red_next;
            lamp_yellow <= yel_next;
            lamp_green  <= grn_next;
        end
    end

endmodule

// File: tb/tb_phase_scheduler.sv
// Phase scheduler bench: directed scenarios with literal expectations plus
// randomized traffic, all checked every cycle against a cycle-count model.
module tb_phase_scheduler;
    import tl_pkg::*;

    localparam int TD = 4;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    phase_scheduler_if bus ();

    phase_scheduler #(.TICK_DIV(TD)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (bus.req),
        .emerg_valid (bus.emerg_valid),
        .emerg_dir   (bus.emerg_dir),
        .min_green   (bus.min_green),
        .max_green   (bus.max_green),
        .yellow_dur  (bus.yellow_dur),
        .all_red_dur (bus.all_red_dur),
        .lamp_red    (bus.lamp_red),
        .lamp_yellow (bus.lamp_yellow),
        .lamp_green  (bus.lamp_green),
        .active_dir  (bus.active_dir),
        .countdown   (bus.countdown),
        .phase       (bus.phase),
        .emerg_ack   (bus.emerg_ack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_st: 0 rest-red, 1 green, 2 yellow, 3 all-red. m_cyc counts whole
    // cycles spent in the current phase, so ticks = m_cyc / TD.
    int m_st, m_dir, m_cyc, m_dur, m_min, m_max, m_ack, m_fresh, m_valid = 0;
    int e_red, e_yel, e_grn, e_dir, e_cd, e_ph, e_ack;
    int r, ev, ed, ticks, tnow, el, oth, enter;

    function automatic int clampd(input int d);
        return (d == 0) ? 1 : d;
    endfunction

    function automatic int next_rr(input int rq, input int last);
        for (int k = 1; k <= 4; k++)
            if (rq[(last + k) % 4]) return (last + k) % 4;
        return last;
    endfunction

    task automatic grant();
        if (ev != 0) begin
            m_dir = ed;
            m_ack = 1;
        end else begin
            m_dir = next_rr(r, m_dir);
            m_ack = 0;
        end
        m_min = clampd(int'(bus.min_green));
        m_max = (int'(bus.max_green) < m_min) ? m_min : int'(bus.max_green);
        m_st  = 1;
        enter = 1;
    endtask

    always @(posedge clk) begin
        r  = int'(bus.req);
        ev = int'(bus.emerg_valid);
        ed = int'(bus.emerg_dir);
        if (reset) begin
            m_st = 3; m_dir = 3; m_cyc = 0; m_ack = 0; m_fresh = 1; m_dur = 0;
            m_valid = 1;
            e_red = 15; e_yel = 0; e_grn = 0; e_dir = 3; e_cd = 0; e_ph = 3; e_ack = 0;
        end else if (m_valid != 0) begin
            ticks = (m_cyc + 1) / TD;
            tnow  = ((m_cyc + 1) % TD == 0) ? 1 : 0;
            enter = 0;
            case (m_st)
                0: if (ev != 0 || r != 0) grant();
                1: begin
                    el  = (ticks < m_max) ? ticks : m_max;
                    oth = ((r & ~(1 << m_dir) & 15) != 0) ? 1 : 0;
                    if (m_ack != 0 && ev != 0) begin
                        m_ack = 1;
                    end else if (m_ack == 0 && ev != 0 && ed == m_dir) begin
                        m_ack = 1;
                    end else if (m_ack == 0 && ev != 0) begin
                        m_st = 2; m_dur = clampd(int'(bus.yellow_dur)); m_ack = 0; enter = 1;
                    end else begin
                        m_ack = 0;
                        if (el >= m_min && oth != 0) begin
                            m_st = 2; m_dur = clampd(int'(bus.yellow_dur)); enter = 1;
                        end
                    end
                end
                2: if (tnow != 0 && ticks == m_dur) begin
                    m_st = 3; m_dur = clampd(int'(bus.all_red_dur)); m_fresh = 0; enter = 1;
                end
                default: begin
                    if (m_fresh != 0) m_dur = clampd(int'(bus.all_red_dur));
                    m_fresh = 0;
                    if (tnow != 0 && ticks == m_dur) begin
                        if (ev != 0 || r != 0) grant();
                        else begin m_st = 0; enter = 1; end
                    end
                end
            endcase
            m_cyc = (enter != 0) ? 0 : m_cyc + 1;
            e_ph = m_st; e_dir = m_dir; e_ack = m_ack;
            e_red = 15; e_yel = 0; e_grn = 0; e_cd = 0;
            if (m_st == 1) begin
                e_grn = 1 << m_dir; e_red = 15 & ~(1 << m_dir);
                el  = (m_cyc / TD < m_max) ? m_cyc / TD : m_max;
                oth = ((r & ~(1 << m_dir) & 15) != 0) ? 1 : 0;
                e_cd = (el < m_min) ? m_min - el : ((oth != 0) ? m_max - el : 0);
            end else if (m_st == 2) begin
                e_yel = 1 << m_dir; e_red = 15 & ~(1 << m_dir);
                e_cd  = m_dur - m_cyc / TD;
            end else if (m_st == 3) begin
                e_cd = m_dur - m_cyc / TD;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_valid != 0) begin
            chk("m_lamp_red",    32'(bus.lamp_red),    32'(e_red));
            chk("m_lamp_yellow", 32'(bus.lamp_yellow), 32'(e_yel));
            chk("m_lamp_green",  32'(bus.lamp_green),  32'(e_grn));
            chk("m_active_dir",  32'(bus.active_dir),  32'(e_dir));
            chk("m_countdown",   32'(bus.countdown),   32'(e_cd));
            chk("m_phase",       32'(bus.phase),       32'(e_ph));
            chk("m_emerg_ack",   32'(bus.emerg_ack),   32'(e_ack));
        end
    end

    // ---------------- stimulus ----------------
    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        edges(2);
        reset = 1'b0;
    endtask

    task automatic set_cfg(input int mg, input int xg, input int yd, input int ad);
        bus.min_green   = 8'(mg);
        bus.max_green   = 8'(xg);
        bus.yellow_dur  = 8'(yd);
        bus.all_red_dur = 8'(ad);
    endtask

    initial begin
        reset = 1'b1;
        bus.req = 4'b0000; bus.emerg_valid = 1'b0; bus.emerg_dir = 2'd0;
        set_cfg(2, 5, 1, 1);

        // Basic cycle: N granted after the post-reset all-red, then rests.
        bus.req = 4'b0001;
        do_reset();
        chk("rst_countdown", 32'(bus.countdown), 32'd0);
        edges(3);
        chk("a_allred_red", 32'(bus.lamp_red), 32'd15);
        edges(1);
        chk("a_green_n", 32'(bus.lamp_green), 32'd1);
        chk("a_cd_entry", 32'(bus.countdown), 32'd2);
        edges(20);
        chk("a_rest_green", 32'(bus.lamp_green), 32'd1);
        chk("a_rest_cd0", 32'(bus.countdown), 32'd0);
        chk("a_rest_phase", 32'(bus.phase), 32'd1);

        // Exit from green on S demand.
        do_reset();
        edges(4);
        bus.req = 4'b0101;
        edges(7);
        chk("b_still_green", 32'(bus.lamp_green), 32'd1);
        edges(1);
        chk("b_yellow_n", 32'(bus.lamp_yellow), 32'd1);
        edges(4);
        chk("b_allred", 32'(bus.phase), 32'd3);
        edges(3);
        chk("b_allred_red", 32'(bus.lamp_red), 32'd15);
        edges(1);
        chk("b_green_s", 32'(bus.lamp_green), 32'd4);
        chk("b_dir_s", 32'(bus.active_dir), 32'd2);

        // Round robin with all directions demanding.
        bus.req = 4'b1111;
        do_reset();
        edges(4);
        for (int k = 0; k < 5; k++) begin
            chk("c_rr_green", 32'(bus.lamp_green), 32'(1 << (k % 4)));
            chk("c_rr_dir", 32'(bus.active_dir), 32'(k % 4));
            edges(7);
            chk("c_rr_hold", 32'(bus.lamp_green), 32'(1 << (k % 4)));
            edges(1);
            chk("c_rr_yellow", 32'(bus.lamp_yellow), 32'(1 << (k % 4)));
            if (k < 4) edges(8);
        end

        // Preemption: E green, emergency for W.
        bus.req = 4'b0010;
        do_reset();
        edges(4);
        chk("d_green_e", 32'(bus.lamp_green), 32'd2);
        bus.emerg_valid = 1'b1; bus.emerg_dir = 2'd3;
        edges(1);
        chk("d_yellow_e", 32'(bus.lamp_yellow), 32'd2);
        edges(4);
        chk("d_allred", 32'(bus.phase), 32'd3);
        edges(4);
        chk("d_green_w", 32'(bus.lamp_green), 32'd8);
        chk("d_ack", 32'(bus.emerg_ack), 32'd1);
        bus.emerg_dir = 2'd0;
        edges(20);
        chk("d_hold_w", 32'(bus.lamp_green), 32'd8);
        chk("d_hold_ack", 32'(bus.emerg_ack), 32'd1);
        bus.emerg_valid = 1'b0;
        edges(1);
        chk("d_ack_drop", 32'(bus.emerg_ack), 32'd0);
        chk("d_yellow_w", 32'(bus.lamp_yellow), 32'd8);

        // Clamps: yellow 0 -> 1 tick, max below min -> min.
        set_cfg(2, 1, 0, 1);
        bus.req = 4'b0101;
        do_reset();
        edges(4);
        chk("e_cd_entry", 32'(bus.countdown), 32'd2);
        edges(7);
        chk("e_green", 32'(bus.lamp_green), 32'd1);
        edges(1);
        chk("e_yellow", 32'(bus.lamp_yellow), 32'd1);
        chk("e_yellow_cd", 32'(bus.countdown), 32'd1);
        edges(3);
        chk("e_yellow_end", 32'(bus.lamp_yellow), 32'd1);
        edges(1);
        chk("e_allred", 32'(bus.phase), 32'd3);

        // Reset in the middle of yellow.
        set_cfg(2, 5, 1, 1);
        do_reset();
        edges(12);
        chk("f_yellow", 32'(bus.lamp_yellow), 32'd1);
        edges(1);
        reset = 1'b1;
        edges(1);
        chk("f_red", 32'(bus.lamp_red), 32'd15);
        chk("f_yel0", 32'(bus.lamp_yellow), 32'd0);
        chk("f_grn0", 32'(bus.lamp_green), 32'd0);
        chk("f_dir3", 32'(bus.active_dir), 32'd3);
        chk("f_cd0", 32'(bus.countdown), 32'd0);
        reset = 1'b0;

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 7) == 0)
                bus.req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            if (!bus.emerg_valid && $urandom_range(0, 59) == 0) begin
                bus.emerg_valid = 1'b1;
                bus.emerg_dir   = 2'($urandom_range(0, 3));
            end else if (bus.emerg_valid && $urandom_range(0, 24) == 0) begin
                bus.emerg_valid = 1'b0;
            end
            if ($urandom_range(0, 15) == 0) bus.emerg_dir = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 49) == 0)
                set_cfg($urandom_range(0, 3), $urandom_range(0, 5),
                        $urandom_range(0, 3), $urandom_range(0, 3));
            reset = ($urandom_range(0, 399) == 0);
        end
        reset = 1'b0;
        edges(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
